// File: rtl/ysyx_23060187_idex_stage.sv
// ID/EX pipeline stage: a two-entry skid buffer feeding the ALU operand muxes.
// Define YSYX_23060187_IDEX_FWD_EN to compile in writeback forwarding into captured and held entries.
module ysyx_23060187_idex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_ALUctrl,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_src1_sel,
    input  logic        in_src2_sel,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic        flush,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  ALUctrl,
    output logic [31:0] opnum1,
    output logic [31:0] opnum2,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen
);

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        src1_sel;
        logic        src2_sel;
        logic [4:0]  rd;
        logic        rd_wen;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d;
    entry_t in_entry, in_p, main_p, skid_p;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic   accept, consume;

    always_comb begin
        in_entry = '{alu_ctrl: in_ALUctrl, pc: in_pc, rs1_data: in_rs1_data,
                     rs2_data: in_rs2_data, rs1: in_rs1, rs2: in_rs2, imm: in_imm,
                     src1_sel: in_src1_sel, src2_sel: in_src2_sel, rd: in_rd,
                     rd_wen: in_rd_wen};
    end

`ifdef YSYX_23060187_IDEX_FWD_EN
    function automatic entry_t fwd(input entry_t e, input logic wen, input logic [4:0] rd,
                                   input logic [31:0] data);
        entry_t r;
        r = e;
        if (wen && rd != 5'd0) begin
            if (e.rs1 == rd) r.rs1_data = data;
            if (e.rs2 == rd) r.rs2_data = data;
        end
        return r;
    endfunction

    always_comb begin
        in_p   = fwd(in_entry, wb_wen, wb_rd, wb_data);
        main_p = main_valid_q ? fwd(main_q, wb_wen, wb_rd, wb_data) : main_q;
        skid_p = skid_valid_q ? fwd(skid_q, wb_wen, wb_rd, wb_data) : skid_q;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_wen, wb_rd, wb_data};

    always_comb begin
        in_p   = in_entry;
        main_p = main_q;
        skid_p = skid_q;
    end
`endif

    assign accept  = in_valid && in_ready_q;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_p;
        skid_d       = skid_p;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = in_p;
                main_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (accept && consume) begin
                main_d = in_p;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                skid_d       = in_p;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            main_d       = skid_p;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !(main_valid_d && skid_valid_d);
        end
    end

    // Outputs come from MAIN registers only, so there is no input-to-output path.
    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign ALUctrl    = main_q.alu_ctrl;
    assign opnum1     = main_q.src1_sel ? main_q.pc : main_q.rs1_data;
    assign opnum2     = main_q.src2_sel ? main_q.imm : main_q.rs2_data;
    assign out_pc     = main_q.pc;
    assign out_rd     = main_q.rd;
    assign out_rd_wen = main_q.rd_wen;

endmodule

// File: tb/tb_ysyx_23060187_idex_stage.sv
// Directed self-checking bench for ysyx_23060187_idex_stage; expectations honour
// YSYX_23060187_IDEX_FWD_EN when the bench is built with it.
module tb_ysyx_23060187_idex_stage;

`ifdef YSYX_23060187_IDEX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_ALUctrl;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_src1_sel, in_src2_sel, in_rd_wen;
    logic        flush, wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  ALUctrl;
    logic [31:0] opnum1, opnum2, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_wen;

    int checks;
    int failures;

    ysyx_23060187_idex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ALUctrl  (in_ALUctrl),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_src1_sel (in_src1_sel),
        .in_src2_sel (in_src2_sel),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .flush       (flush),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUctrl     (ALUctrl),
        .opnum1      (opnum1),
        .opnum2      (opnum2),
        .out_pc      (out_pc),
        .out_rd      (out_rd),
        .out_rd_wen  (out_rd_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] alu, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] imm, input logic s1, input logic s2,
                          input logic [4:0] rd, input logic rdw);
        in_ALUctrl  = alu;
        in_pc       = pc;
        in_rs1_data = r1d;
        in_rs2_data = r2d;
        in_rs1      = r1;
        in_rs2      = r2;
        in_imm      = imm;
        in_src1_sel = s1;
        in_src2_sel = s2;
        in_rd       = rd;
        in_rd_wen   = rdw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid got=%0h want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready got=%0h want=1", in_ready); end
        checks++; if (ALUctrl !== 4'd0) begin failures++;
            $display("FAIL reset_aluctrl got=%0h want=0", ALUctrl); end
        checks++; if (opnum1 !== 32'd0) begin failures++;
            $display("FAIL reset_opnum1 got=%0h want=0", opnum1); end
        checks++; if (opnum2 !== 32'd0) begin failures++;
            $display("FAIL reset_opnum2 got=%0h want=0", opnum2); end
        checks++; if (out_pc !== 32'd0) begin failures++;
            $display("FAIL reset_out_pc got=%0h want=0", out_pc); end
        checks++; if (out_rd !== 5'd0) begin failures++;
            $display("FAIL reset_out_rd got=%0h want=0", out_rd); end
        checks++; if (out_rd_wen !== 1'b0) begin failures++;
            $display("FAIL reset_out_rd_wen got=%0h want=0", out_rd_wen); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        set_in(4'd2, 32'h100, 32'd5, 32'd7, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++;
            $display("FAIL add_out_valid got=%0h want=1", out_valid); end
        checks++; if (ALUctrl !== 4'd2) begin failures++;
            $display("FAIL add_aluctrl got=%0h want=2", ALUctrl); end
        checks++; if (opnum1 !== 32'd5) begin failures++;
            $display("FAIL add_opnum1 got=%0h want=5", opnum1); end
        checks++; if (opnum2 !== 32'd7) begin failures++;
            $display("FAIL add_opnum2 got=%0h want=7", opnum2); end
        checks++; if (out_pc !== 32'h100) begin failures++;
            $display("FAIL add_out_pc got=%0h want=100", out_pc); end
        checks++; if (out_rd !== 5'd4 || out_rd_wen !== 1'b1) begin failures++;
            $display("FAIL add_rd got=%0h/%0h want=4/1", out_rd, out_rd_wen); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL add_drain got=%0h want=0", out_valid); end
    endtask

    task automatic test_sub_pc_imm();
        out_ready = 1'b1;
        set_in(4'd6, 32'h8000_0000, 32'h55, 32'h66, 5'd1, 5'd2, 32'h4, 1'b1, 1'b1, 5'd9, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (ALUctrl !== 4'd6) begin failures++;
            $display("FAIL sub_aluctrl got=%0h want=6", ALUctrl); end
        checks++; if (opnum1 !== 32'h8000_0000) begin failures++;
            $display("FAIL sub_opnum1 got=%0h want=80000000", opnum1); end
        checks++; if (opnum2 !== 32'h4) begin failures++;
            $display("FAIL sub_opnum2 got=%0h want=4", opnum2); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_in(4'd0, 32'hA0, 32'h11, 32'h1, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1);
        in_valid = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || opnum1 !== 32'h11) begin failures++;
            $display("FAIL b2b_a_in got=%0h/%0h want=1/11", in_ready, opnum1); end
        set_in(4'd1, 32'hB0, 32'h22, 32'h2, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd2, 1'b1);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++;
            $display("FAIL b2b_full_ready got=%0h want=0", in_ready); end
        checks++; if (opnum1 !== 32'h11 || ALUctrl !== 4'd0) begin failures++;
            $display("FAIL b2b_full_hold got=%0h/%0h want=11/0", opnum1, ALUctrl); end
        set_in(4'd2, 32'hC0, 32'h33, 32'h3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd3, 1'b1);
        step();
        checks++; if (in_ready !== 1'b0 || opnum1 !== 32'h11 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall got=%0h/%0h/%0h want=0/11/1", in_ready, opnum1, out_valid);
        end
        out_ready = 1'b1;
        step();
        checks++; if (opnum1 !== 32'h22 || ALUctrl !== 4'd1 || out_pc !== 32'hB0) begin
            failures++;
            $display("FAIL b2b_second got=%0h/%0h/%0h want=22/1/b0", opnum1, ALUctrl, out_pc);
        end
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL b2b_reopen got=%0h want=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (opnum1 !== 32'h33 || ALUctrl !== 4'd2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_third got=%0h/%0h/%0h want=33/2/1", opnum1, ALUctrl, out_valid);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL b2b_empty got=%0h want=0", out_valid); end
    endtask

    task automatic test_throughput();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(4'd2, 32'h200 + i, 32'h100 + i, 32'h0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0,
                   5'd5, 1'b1);
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || opnum1 !== 32'h100 + i || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d got=%0h/%0h/%0h want=1/%0h/1", i, out_valid, opnum1,
                         in_ready, 32'h100 + i);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL stream_drain got=%0h want=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(4'd0, 32'h10, 32'hAAA, 32'h0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1);
        in_valid = 1'b1;
        step();
        set_in(4'd1, 32'h14, 32'hBBB, 32'h0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1);
        step();
        set_in(4'd2, 32'h18, 32'hCCC, 32'h0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL flush_state got=%0h/%0h want=0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++;
                $display("FAIL flush_ghost_%0d got=%0h want=0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_in(4'd2, 32'h40, 32'h777, 32'h0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 5'd6, 1'b1);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || opnum1 !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid got=%0h/%0h/%0h want=0/1/0", out_valid, in_ready, opnum1);
        end
    endtask

    task automatic test_forward();
        logic [31:0] exp1;
        exp1 = FWD ? 32'hDEAD : 32'h1234;
        out_ready = 1'b0;
        set_in(4'd2, 32'h0, 32'h1234, 32'h77, 5'd3, 5'd7, 32'h0, 1'b0, 1'b0, 5'd8, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
        step();
        wb_wen = 1'b0;
        checks++; if (opnum1 !== exp1) begin failures++;
            $display("FAIL fwd_main_rs1 got=%0h want=%0h", opnum1, exp1); end
        checks++; if (opnum2 !== 32'h77) begin failures++;
            $display("FAIL fwd_main_rs2 got=%0h want=77", opnum2); end
        wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
        step();
        wb_wen = 1'b0;
        checks++; if (opnum1 !== exp1) begin failures++;
            $display("FAIL fwd_x0 got=%0h want=%0h", opnum1, exp1); end
        // Capture-time forwarding while the held entry is consumed.
        out_ready = 1'b1;
        set_in(4'd2, 32'h0, 32'h99, 32'h55, 5'd9, 5'd5, 32'h0, 1'b0, 1'b0, 5'd8, 1'b1);
        in_valid = 1'b1;
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE;
        step();
        in_valid = 1'b0;
        wb_wen = 1'b0;
        checks++; if (opnum1 !== 32'h99) begin failures++;
            $display("FAIL fwd_cap_rs1 got=%0h want=99", opnum1); end
        checks++; if (opnum2 !== (FWD ? 32'hCAFE : 32'h55)) begin failures++;
            $display("FAIL fwd_cap_rs2 got=%0h want=%0h", opnum2, FWD ? 32'hCAFE : 32'h55); end
        step();
        // SKID entry patched, then promoted to MAIN.
        out_ready = 1'b0;
        set_in(4'd2, 32'h0, 32'h10, 32'h0, 5'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd8, 1'b1);
        in_valid = 1'b1;
        step();
        set_in(4'd2, 32'h0, 32'h20, 32'h0, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0, 5'd8, 1'b1);
        step();
        in_valid = 1'b0;
        wb_wen = 1'b1; wb_rd = 5'd2; wb_data = 32'hF00D;
        step();
        wb_wen = 1'b0;
        checks++; if (opnum1 !== 32'h10) begin failures++;
            $display("FAIL fwd_skid_main got=%0h want=10", opnum1); end
        out_ready = 1'b1;
        step();
        checks++; if (opnum1 !== (FWD ? 32'hF00D : 32'h20)) begin failures++;
            $display("FAIL fwd_skid_rs1 got=%0h want=%0h", opnum1, FWD ? 32'hF00D : 32'h20); end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        wb_wen = 1'b0;
        wb_rd = 5'd0;
        wb_data = 32'd0;
        set_in(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_add();
        test_sub_pc_imm();
        test_back_to_back();
        test_throughput();
        test_flush();
        test_reset_mid();
        test_forward();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_idex_stage.md
# ysyx_23060187_idex_stage

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It registers one decoded instruction's ALU control code, raw register operands, immediate and PC, and selects the two ALU operands. It optionally patches stale register operands with the writeback result. A two-entry skid buffer keeps `in_ready` a registered signal while decoupling decode from execute back-pressure.

## Interface
- No parameters; data width is fixed at 32, register index width at 5.
- `clk`  in  1  Sole clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  Decode presents an instruction.
- `in_ready`  out  1  Stage can accept; registered.
- `in_ALUctrl`  in  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, others give a result of 0.
- `in_pc`  in  32  Instruction PC.
- `in_rs1_data`, `in_rs2_data`  in  32 each  Register-file read data.
- `in_rs1`, `in_rs2`  in  5 each  Source register indices.
- `in_imm`  in  32  Sign-extended immediate.
- `in_src1_sel`  in  1  Operand-1 source: 0 rs1, 1 pc.
- `in_src2_sel`  in  1  Operand-2 source: 0 rs2, 1 imm.
- `in_rd`  in  5  Destination index.
- `in_rd_wen`  in  1  Destination write enable.
- `flush`  in  1  Discard all held and incoming instructions this cycle.
- `wb_wen`  in  1  Writeback write enable.
- `wb_rd`  in  5  Writeback destination index.
- `wb_data`  in  32  Writeback data.
- `out_valid`  out  1  Operands valid toward the ALU.
- `out_ready`  in  1  Execute accepts.
- `ALUctrl`  out  4  Registered ALU op.
- `opnum1`, `opnum2`  out  32 each  Selected ALU operands.
- `out_pc`  out  32  PC of the instruction.
- `out_rd`  out  5  Destination index.
- `out_rd_wen`  out  1  Destination write enable.

## Operation
- Storage: MAIN entry, which drives the outputs, and SKID entry. Each holds every `in_*` field plus a valid bit.
- Occupancy states:
  - EMPTY: neither entry valid.
  - ONE: only MAIN valid.
  - FULL: MAIN and SKID both valid.
  - SKID is never valid while MAIN is invalid.
- Accept: handshake when `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- Transitions when `flush` is low:
  - EMPTY + accept → ONE.
  - ONE + accept + consume → ONE, with the new data in MAIN.
  - ONE + accept, no consume → FULL, with the new data in SKID.
  - ONE + consume → EMPTY.
  - FULL + consume → ONE, with SKID moved into MAIN.
  - Accept cannot occur in FULL.
- `in_ready` = next-state occupancy is not FULL, registered. It equals 1 in EMPTY and ONE, and 0 in FULL.
- `out_valid` = MAIN valid.
- `opnum1` = `in_src1_sel` of MAIN ? pc : rs1 value.
- `opnum2` = `in_src2_sel` of MAIN ? imm : rs2 value.
- Output operand muxes are combinational from MAIN registers only; there is no input-to-output combinational path.
- `flush` has priority over everything:
  - Next state is EMPTY and `in_ready` becomes 1.
  - An accept in the flush cycle is discarded.
  - A consume in the flush cycle still counts downstream; the stage takes no further action on it.
- Outputs do not change while `out_valid && !out_ready`, except for the forwarding patch (see Configuration).

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N, in cycle N+1, when the stage was EMPTY or consumed in the same cycle.
- Throughput: one instruction per cycle while `out_ready` is held high.
- Back-pressure: one cycle after `out_ready` drops, up to two instructions are held. `in_ready` falls after the second is accepted.
- Reset (synchronous):
  - All valid bits are 0; `out_valid` = 0; `in_ready` = 1.
  - All data outputs are 0: `ALUctrl`, `opnum1`, `opnum2`, `out_pc`, `out_rd` and `out_rd_wen`.
  - Reset asserted mid-transfer drops everything, with the same effect as `flush`.
- Register index 0 is never forwarded.

## Configuration
- Macro `YSYX_23060187_IDEX_FWD_EN`.
- Defined: writeback forwarding is compiled in.
  - Applies when `wb_wen && wb_rd != 0`.
  - Capture: `wb_rd == in_rs1` or `wb_rd == in_rs2` makes the captured rs data `wb_data` instead of the register-file data.
  - Held entries: every valid MAIN or SKID entry with a matching rs1 or rs2 index updates that stored value to `wb_data` on the same edge.
  - `opnum1` and `opnum2` may therefore change while stalled.
- Undefined: no forwarding.
  - `wb_*` inputs are ignored.
  - Stored data changes only on capture.

## Test plan
- Reset, then idle → `out_valid`=0, `in_ready`=1, every data output 0.
- Accept ADD with rs1_data=5, rs2_data=7, both selects 0, `out_ready`=1 → next cycle `ALUctrl`=2, `opnum1`=5, `opnum2`=7, `out_valid`=1.
- `out_ready`=0, three back-to-back valid inputs A, B, C → A and B accepted, `in_ready`=0 after B, C held off. Raise `out_ready` → A, B, C emerge in order over three cycles with no duplicate and no loss.
- SUB with `in_src1_sel`=1, `in_pc`=0x80000000, `in_src2_sel`=1, `in_imm`=0x4 → `opnum1`=0x80000000, `opnum2`=4, `ALUctrl`=6.
- FULL state, assert `flush` together with a valid input → next cycle `out_valid`=0, `in_ready`=1; none of the three instructions ever appears.
- With `YSYX_23060187_IDEX_FWD_EN`: MAIN holds rs1=3 stalled, then `wb_wen`=1, `wb_rd`=3, `wb_data`=0xDEAD → `opnum1`=0xDEAD the next cycle. `wb_rd`=0 leaves it unchanged. Without the macro, `opnum1` remains the original value.
